// File: rtl/zeroriscy_d_loader.sv
// Boot-time program loader in front of the data SRAM port; transparent core pass-through when idle.
// Optional trailing checksum byte and ld_err reporting are enabled by defining LOADER_CHECKSUM_EN.
module zeroriscy_d_loader #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ld_valid,
   input  logic [7:0]        ld_data,
   output logic              ld_ready,
   output logic              ld_busy,
   output logic              ld_done,
   output logic              ld_err,
   output logic              core_hold,
   input  logic              c_req,
   input  logic              c_we,
   input  logic [3:0]        c_be,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [31:0]       c_wdata,
   output logic [31:0]       c_rdata,
   output logic              c_gnt,
   output logic              c_rvalid,
   output logic              c_err,
   output logic              m_req,
   output logic              m_we,
   output logic [3:0]        m_be,
   output logic [ADDR_W-1:0] m_addr,
   output logic [31:0]       m_wdata,
   input  logic [31:0]       m_rdata,
   input  logic              m_gnt,
   input  logic              m_rvalid,
   input  logic              m_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_DATA,
      S_WRITE,
      S_CKSUM,
      S_DONE
   } state_t;

`ifdef LOADER_CHECKSUM_EN
   localparam state_t END_STATE = S_CKSUM;
`else
   localparam state_t END_STATE = S_DONE;
`endif

   state_t            state, state_nx;
   logic [2:0]        hdr_cnt;
   logic [55:0]       hdr_sr;
   logic [ADDR_W-1:0] cur_addr;
   logic [31:0]       remaining;
   logic [7:0]        data_byte;
   logic              hold;
   logic              owner_ldr;
   logic              accept;
   logic [31:0]       len_full;

   // Header bytes shift in from the top, so after seven bytes byte 0 sits in bits [7:0].
   assign accept   = ld_valid & ld_ready;
   assign len_full = {ld_data, hdr_sr[55:32]};

   assign ld_ready  = (state == S_IDLE) || (state == S_HDR) || (state == S_DATA) || (state == S_CKSUM);
   assign ld_busy   = (state != S_IDLE) && (state != S_DONE);
   assign ld_done   = (state == S_DONE);
   assign core_hold = hold;

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (accept) state_nx = S_HDR;
         S_HDR:   if (accept && hdr_cnt == 3'd7) state_nx = (len_full == 32'd0) ? END_STATE : S_DATA;
         S_DATA:  if (accept) state_nx = S_WRITE;
         S_WRITE: if (m_gnt) state_nx = (remaining == 32'd1) ? END_STATE : S_DATA;
         S_CKSUM: if (accept) state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         hdr_cnt   <= 3'd0;
         hdr_sr    <= 56'd0;
         cur_addr  <= '0;
         remaining <= 32'd0;
         data_byte <= 8'd0;
         hold      <= 1'b1;
         owner_ldr <= 1'b0;
      end else begin
         state <= state_nx;
         // Remember who issued each granted request so the response goes back to the right master.
         if (m_req && m_gnt) owner_ldr <= (state != S_IDLE);
         case (state)
            S_IDLE: begin
               if (accept) begin
                  hdr_sr  <= {ld_data, hdr_sr[55:8]};
                  hdr_cnt <= 3'd1;
               end
            end
            S_HDR: begin
               if (accept) begin
                  hdr_sr  <= {ld_data, hdr_sr[55:8]};
                  hdr_cnt <= hdr_cnt + 3'd1;
                  if (hdr_cnt == 3'd7) begin
                     cur_addr  <= ADDR_W'(hdr_sr[31:0]);
                     remaining <= len_full;
                  end
               end
            end
            S_DATA: begin
               if (accept) data_byte <= ld_data;
            end
            S_WRITE: begin
               if (m_gnt) begin
                  cur_addr  <= cur_addr + ADDR_W'(1);
                  remaining <= remaining - 32'd1;
               end
            end
            S_DONE: begin
               if (!ld_err) hold <= 1'b0;
            end
            default: ;
         endcase
      end
   end

`ifdef LOADER_CHECKSUM_EN
   logic [7:0] sum;
   logic [7:0] sum_total;
   logic       err;

   assign sum_total = sum + ld_data;

   // Running sum over header and payload; the trailing byte must bring the total to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum <= 8'd0;
         err <= 1'b0;
      end else if (accept) begin
         if (state == S_IDLE) begin
            sum <= ld_data;
            err <= 1'b0;
         end else if (state == S_CKSUM) begin
            if (sum_total != 8'd0) err <= 1'b1;
         end else begin
            sum <= sum_total;
         end
      end
   end

   assign ld_err = err;
`else
   assign ld_err = 1'b0;
`endif

   always_comb begin
      m_req   = 1'b0;
      m_we    = 1'b0;
      m_be    = 4'd0;
      m_addr  = cur_addr;
      m_wdata = {4{data_byte}};
      c_gnt   = 1'b0;
      case (state)
         S_IDLE: begin
            m_req   = c_req;
            m_we    = c_we;
            m_be    = c_be;
            m_addr  = c_addr;
            m_wdata = c_wdata;
            c_gnt   = m_gnt;
         end
         S_WRITE: begin
            m_req = 1'b1;
            m_we  = 1'b1;
            m_be  = 4'b0001 << cur_addr[1:0];
         end
         default: ;
      endcase
   end

   assign c_rvalid = m_rvalid & ~owner_ldr;
   assign c_err    = m_rvalid & ~owner_ldr & m_err;
   assign c_rdata  = m_rdata;

endmodule

// File: tb/tb_zeroriscy_d_loader.sv
// Self-checking bench for zeroriscy_d_loader: SRAM model, frame driver and reference write model.
// Checksum scenarios are compiled in when LOADER_CHECKSUM_EN is defined.
module tb_zeroriscy_d_loader;

`ifdef LOADER_CHECKSUM_EN
   localparam int CK = 1;
`else
   localparam int CK = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ld_valid;
   logic [7:0]  ld_data;
   logic        ld_ready, ld_busy, ld_done, ld_err, core_hold;
   logic        c_req, c_we;
   logic [3:0]  c_be;
   logic [31:0] c_addr, c_wdata, c_rdata;
   logic        c_gnt, c_rvalid, c_err;
   logic        m_req, m_we;
   logic [3:0]  m_be;
   logic [31:0] m_addr, m_wdata;
   logic [31:0] m_rdata = 32'd0;
   logic        m_gnt;
   logic        m_rvalid = 1'b0;
   logic        m_err = 1'b0;
   logic        gnt_force, gnt_val;
   logic        gnt_rand = 1'b1;

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;
   int crv_cnt = 0;
   int cyc = 0;
   bit exp_hold;

   logic [31:0] wr_addr_q[$];
   logic [3:0]  wr_be_q[$];
   logic [31:0] wr_data_q[$];
   logic [7:0]  payload[$];

   always #5 clk = ~clk;

   assign m_gnt = gnt_force ? gnt_val : gnt_rand;

   zeroriscy_d_loader #(.ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready), .ld_busy(ld_busy),
      .ld_done(ld_done), .ld_err(ld_err), .core_hold(core_hold),
      .c_req(c_req), .c_we(c_we), .c_be(c_be), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_rdata(c_rdata), .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_err(c_err),
      .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_err(m_err)
   );

   // SRAM model: one-cycle response to every granted request, error flagged at 0xBAD0, writes logged.
   always @(posedge clk) begin
      cyc      <= cyc + 1;
      m_rvalid <= m_req && m_gnt;
      m_rdata  <= 32'hA500_0000 ^ m_addr;
      m_err    <= m_req && m_gnt && (m_addr == 32'h0000_BAD0);
      if (ld_done) done_cnt <= done_cnt + 1;
      if (c_rvalid) crv_cnt <= crv_cnt + 1;
      if (m_req && m_gnt && m_we) begin
         wr_addr_q.push_back(m_addr);
         wr_be_q.push_back(m_be);
         wr_data_q.push_back(m_wdata);
      end
   end

   always @(negedge clk) gnt_rand <= 1'($urandom_range(0, 1));

   task automatic send_byte(input logic [7:0] b);
      int w = 0;
      @(negedge clk);
      ld_valid = 1'b1;
      ld_data  = b;
      while (!ld_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (!ld_ready) begin
         checks++;
         errors++;
         $display("[TB] FAIL send_timeout: ld_ready=%b required 1", ld_ready);
         ld_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1 ld_valid = 1'b0;
      end
   endtask

   task automatic drive_frame(input logic [31:0] addr, input bit bad_ck, input int maxgap,
                              output int t_first);
      logic [7:0]  bytes[$];
      logic [31:0] len;
      logic [7:0]  sum;
      len = 32'(payload.size());
      for (int i = 0; i < 4; i++) bytes.push_back(addr[8*i +: 8]);
      for (int i = 0; i < 4; i++) bytes.push_back(len[8*i +: 8]);
      foreach (payload[i]) bytes.push_back(payload[i]);
      sum = 8'd0;
      foreach (bytes[i]) sum = sum + bytes[i];
      if (CK == 1) bytes.push_back(bad_ck ? 8'(8'd1 - sum) : 8'(8'd0 - sum));
      wr_addr_q.delete();
      wr_be_q.delete();
      wr_data_q.delete();
      t_first = 0;
      foreach (bytes[i]) begin
         if (maxgap > 0) repeat ($urandom_range(0, maxgap)) @(negedge clk);
         send_byte(bytes[i]);
         if (i == 0) t_first = cyc;
      end
   endtask

   task automatic wait_done(input string name, output int t_done);
      int w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (ld_done !== 1'b1 && w < 400);
      t_done = cyc;
      if (ld_done !== 1'b1) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s done_timeout: ld_done=%b required 1", name, ld_done);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      checks++;
      if ({ld_ready, ld_busy, ld_done, ld_err, core_hold} !== 5'b10001)
         begin errors++; $display("[TB] FAIL reset_status: got %b required 10001", {ld_ready, ld_busy, ld_done, ld_err, core_hold}); end
      checks++;
      if ({c_rvalid, m_req} !== 2'b00)
         begin errors++; $display("[TB] FAIL reset_req: got %b required 00", {c_rvalid, m_req}); end
      c_req = 1'b1; c_addr = 32'h44; gnt_val = 1'b0;
      #1;
      checks++;
      if ({m_req, c_gnt, m_addr} !== {1'b1, 1'b0, 32'h44})
         begin errors++; $display("[TB] FAIL reset_pass0: got %b%b %h required 1 0 00000044", m_req, c_gnt, m_addr); end
      gnt_val = 1'b1;
      #1;
      checks++;
      if (c_gnt !== 1'b1) begin errors++; $display("[TB] FAIL reset_pass1: c_gnt=%b required 1", c_gnt); end
      c_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({ld_ready, ld_busy, ld_done, ld_err, core_hold, c_rvalid} !== 6'b100010)
         begin errors++; $display("[TB] FAIL after_reset: got %b required 100010", {ld_ready, ld_busy, ld_done, ld_err, core_hold, c_rvalid}); end
   endtask

`ifdef LOADER_CHECKSUM_EN
   task automatic test_bad_checksum();
      int t0, t1, d0;
      payload = '{8'hDE, 8'hAD};
      d0 = done_cnt;
      drive_frame(32'h0000_0400, 1'b1, 0, t0);
      wait_done("bad_ck", t1);
      checks++;
      if ({ld_err, core_hold, 32'(done_cnt - d0)} !== {1'b1, 1'b1, 32'd1})
         begin errors++; $display("[TB] FAIL bad_ck: err=%b hold=%b dones=%0d required 1 1 1", ld_err, core_hold, done_cnt - d0); end
      checks++;
      if (wr_addr_q.size() != 2) begin errors++; $display("[TB] FAIL bad_ck_writes: got %0d required 2", wr_addr_q.size()); end
   endtask
`endif

   task automatic test_len_zero();
      int t0, t1, d0;
      payload.delete();
      d0 = done_cnt;
      drive_frame(32'h0000_2000, 1'b0, 0, t0);
      wait_done("len_zero", t1);
      exp_hold = 1'b0;
      checks++;
      if (wr_addr_q.size() != 0) begin errors++; $display("[TB] FAIL len_zero_writes: got %0d required 0", wr_addr_q.size()); end
      checks++;
      if ({core_hold, ld_err, ld_done, 32'(done_cnt - d0)} !== {exp_hold, 1'b0, 1'b0, 32'd1})
         begin errors++; $display("[TB] FAIL len_zero_status: hold=%b err=%b done=%b pulses=%0d required 0 0 0 1", core_hold, ld_err, ld_done, done_cnt - d0); end
   endtask

   task automatic test_basic();
      int t0, t1, d0, c0;
      payload = '{8'h11, 8'h22, 8'h33, 8'h44};
      d0 = done_cnt; c0 = crv_cnt;
      gnt_force = 1'b1; gnt_val = 1'b1;
      drive_frame(32'h0000_0100, 1'b0, 0, t0);
      wait_done("basic", t1);
      checks++;
      if (t1 - t0 + 1 != 2 * 4 + 8 + CK) begin errors++; $display("[TB] FAIL basic_latency: got %0d required %0d", t1 - t0 + 1, 2 * 4 + 8 + CK); end
      checks++;
      if (wr_addr_q.size() != 4) begin errors++; $display("[TB] FAIL basic_count: got %0d required 4", wr_addr_q.size()); end
      for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
         checks++;
         if ({wr_addr_q[i], wr_be_q[i], wr_data_q[i]} !== {32'h100 + 32'(i), 4'(1 << i), {4{payload[i]}}})
            begin errors++; $display("[TB] FAIL basic_write%0d: got %h/%h/%h required %h/%h/%h", i, wr_addr_q[i], wr_be_q[i], wr_data_q[i], 32'h100 + 32'(i), 4'(1 << i), {4{payload[i]}}); end
      end
      checks++;
      if ({core_hold, ld_busy, 32'(done_cnt - d0), 32'(crv_cnt - c0)} !== {1'b0, 1'b0, 32'd1, 32'd0})
         begin errors++; $display("[TB] FAIL basic_status: hold=%b busy=%b pulses=%0d crv=%0d required 0 0 1 0", core_hold, ld_busy, done_cnt - d0, crv_cnt - c0); end
   endtask

   task automatic test_stall();
      int t0, t1;
      payload = '{8'h5A};
      gnt_force = 1'b1; gnt_val = 1'b0;
      fork
         drive_frame(32'h0000_0202, 1'b0, 0, t0);
         begin
            int w = 0;
            while (m_req !== 1'b1 && w < 100) begin @(negedge clk); w++; end
            for (int i = 0; i < 5; i++) begin
               checks++;
               if ({m_req, m_we, m_addr, m_be, m_wdata, ld_ready} !== {1'b1, 1'b1, 32'h202, 4'h4, 32'h5A5A5A5A, 1'b0})
                  begin errors++; $display("[TB] FAIL stall%0d: req=%b we=%b addr=%h be=%h wdata=%h ready=%b required 1 1 00000202 4 5a5a5a5a 0", i, m_req, m_we, m_addr, m_be, m_wdata, ld_ready); end
               @(negedge clk);
            end
            gnt_val = 1'b1;
         end
      join
      wait_done("stall", t1);
      checks++;
      if (wr_addr_q.size() != 1 || {wr_addr_q[0], wr_be_q[0], wr_data_q[0]} !== {32'h202, 4'h4, 32'h5A5A5A5A})
         begin errors++; $display("[TB] FAIL stall_write: count=%0d required 1 at 00000202", wr_addr_q.size()); end
   endtask

   task automatic test_passthrough();
      int t1;
      logic [31:0] wd;
      logic [7:0]  hdr[$];
      gnt_force = 1'b1; gnt_val = 1'b1;
      @(negedge clk);
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'h8; c_be = 4'hF;
      #1;
      checks++;
      if ({m_req, m_we, m_addr, c_gnt} !== {1'b1, 1'b0, 32'h8, 1'b1})
         begin errors++; $display("[TB] FAIL pass_read_req: got %b %b %h %b required 1 0 00000008 1", m_req, m_we, m_addr, c_gnt); end
      @(negedge clk);
      c_req = 1'b0;
      checks++;
      if ({c_rvalid, c_err, c_rdata} !== {1'b1, 1'b0, 32'hA500_0008})
         begin errors++; $display("[TB] FAIL pass_read_rsp: got %b %b %h required 1 0 a5000008", c_rvalid, c_err, c_rdata); end
      wd = $urandom;
      @(negedge clk);
      c_req = 1'b1; c_we = 1'b1; c_addr = 32'hBAD0; c_be = 4'h6; c_wdata = wd; gnt_val = 1'b0;
      #1;
      checks++;
      if ({m_req, m_we, m_be, m_wdata, c_gnt} !== {1'b1, 1'b1, 4'h6, wd, 1'b0})
         begin errors++; $display("[TB] FAIL pass_write_req: got %b %b %h %h %b required 1 1 6 %h 0", m_req, m_we, m_be, m_wdata, c_gnt, wd); end
      gnt_val = 1'b1;
      @(negedge clk);
      c_req = 1'b0;
      checks++;
      if ({c_rvalid, c_err} !== 2'b11) begin errors++; $display("[TB] FAIL pass_err_rsp: got %b required 11", {c_rvalid, c_err}); end
      // Core read granted in the same cycle the first frame byte leaves IDLE.
      @(negedge clk);
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'h20; ld_valid = 1'b1; ld_data = 8'h40;
      @(posedge clk);
      #1 ld_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({c_rvalid, c_rdata, c_gnt, m_req, ld_busy} !== {1'b1, 32'hA500_0020, 1'b0, 1'b0, 1'b1})
         begin errors++; $display("[TB] FAIL pass_handover: got %b %h %b %b %b required 1 a5000020 0 0 1", c_rvalid, c_rdata, c_gnt, m_req, ld_busy); end
      c_req = 1'b0;
      hdr = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      if (CK == 1) hdr.push_back(8'hC0);
      foreach (hdr[i]) send_byte(hdr[i]);
      wait_done("handover", t1);
      checks++;
      if ({core_hold, ld_err} !== 2'b00) begin errors++; $display("[TB] FAIL handover_status: got %b required 00", {core_hold, ld_err}); end
   endtask

   task automatic test_wrap();
      int t0, t1;
      payload = '{8'hA1, 8'hB2};
      gnt_force = 1'b1; gnt_val = 1'b1;
      drive_frame(32'hFFFF_FFFF, 1'b0, 0, t0);
      wait_done("wrap", t1);
      checks++;
      if (wr_addr_q.size() != 2) begin errors++; $display("[TB] FAIL wrap_count: got %0d required 2", wr_addr_q.size()); end
      else begin
         checks++;
         if ({wr_addr_q[0], wr_be_q[0], wr_addr_q[1], wr_be_q[1]} !== {32'hFFFF_FFFF, 4'h8, 32'h0, 4'h1})
            begin errors++; $display("[TB] FAIL wrap_writes: got %h/%h %h/%h required ffffffff/8 00000000/1", wr_addr_q[0], wr_be_q[0], wr_addr_q[1], wr_be_q[1]); end
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] hdr[8] = '{8'h00, 8'h03, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
      foreach (hdr[i]) send_byte(hdr[i]);
      @(negedge clk);
      checks++;
      if ({ld_busy, ld_ready} !== 2'b11) begin errors++; $display("[TB] FAIL mid_data: got %b required 11", {ld_busy, ld_ready}); end
      rst_n = 1'b0;
      #1;
      exp_hold = 1'b1;
      checks++;
      if ({ld_ready, ld_busy, ld_done, ld_err, core_hold, m_req, c_rvalid} !== 7'b1000100)
         begin errors++; $display("[TB] FAIL mid_reset: got %b required 1000100", {ld_ready, ld_busy, ld_done, ld_err, core_hold, m_req, c_rvalid}); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({core_hold, ld_busy} !== {exp_hold, 1'b0}) begin errors++; $display("[TB] FAIL mid_release: got %b required 10", {core_hold, ld_busy}); end
   endtask

   task automatic test_random();
      int t0, t1, d0, c0, n;
      logic [31:0] addr, ea;
      gnt_force = 1'b0;
      for (int f = 0; f < 5; f++) begin
         addr = $urandom;
         if (f == 0) addr = 32'hFFFF_FFFD;
         n = $urandom_range(1, 6);
         payload.delete();
         for (int i = 0; i < n; i++) payload.push_back(8'($urandom));
         d0 = done_cnt; c0 = crv_cnt;
         drive_frame(addr, 1'b0, 2, t0);
         wait_done("random", t1);
         exp_hold = 1'b0;
         checks++;
         if (wr_addr_q.size() != n) begin errors++; $display("[TB] FAIL rnd%0d_count: got %0d required %0d", f, wr_addr_q.size(), n); end
         for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            ea = addr + 32'(i);
            checks++;
            if ({wr_addr_q[i], wr_be_q[i], wr_data_q[i]} !== {ea, 4'(1 << (ea % 4)), {4{payload[i]}}})
               begin errors++; $display("[TB] FAIL rnd%0d_write%0d: got %h/%h/%h required %h/%h/%h", f, i, wr_addr_q[i], wr_be_q[i], wr_data_q[i], ea, 4'(1 << (ea % 4)), {4{payload[i]}}); end
         end
         checks++;
         if ({core_hold, 32'(done_cnt - d0), 32'(crv_cnt - c0)} !== {exp_hold, 32'd1, 32'd0})
            begin errors++; $display("[TB] FAIL rnd%0d_status: hold=%b pulses=%0d crv=%0d required 0 1 0", f, core_hold, done_cnt - d0, crv_cnt - c0); end
      end
      gnt_force = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; ld_valid = 1'b0; ld_data = 8'd0;
      c_req = 1'b0; c_we = 1'b0; c_be = 4'd0; c_addr = 32'd0; c_wdata = 32'd0;
      gnt_force = 1'b1; gnt_val = 1'b1; exp_hold = 1'b1;
      repeat (3) @(negedge clk);
      test_reset();
`ifdef LOADER_CHECKSUM_EN
      test_bad_checksum();
`endif
      test_len_zero();
      test_basic();
      test_stall();
      test_passthrough();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/zeroriscy_d_loader.md
# zeroriscy_d_loader

Boot-time program loader sitting directly upstream of the data SRAM port, between the core's LSU data port and the SRAM. It accepts a framed byte stream from the host link (UART receiver), writes the payload byte-by-byte into SRAM through the same req/gnt/rvalid protocol the core uses, and holds the core in reset until a load completes. When idle it is a transparent pass-through for the core's data port.

## Interface
Parameters:
- ADDR_W, 32, width of core/SRAM byte address.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ld_valid  in  1  host byte valid.
- ld_data  in  8  host byte.
- ld_ready  out  1  byte accepted when ld_valid & ld_ready.
- ld_busy  out  1  frame in progress (state ≠ IDLE/DONE).
- ld_done  out  1  one-cycle pulse at frame completion.
- ld_err  out  1  sticky checksum error (cleared by next frame start); 0 without macro.
- core_hold  out  1  core reset request; 1 from reset until first successful frame.
- c_req, c_we  in  1  core data request / write.
- c_be  in  4  core byte enables.
- c_addr  in  ADDR_W  core byte address.
- c_wdata  in  32  core write data.
- c_rdata  out  32  read data to core.
- c_gnt, c_rvalid, c_err  out  1  core grant / response valid / error.
- m_req, m_we  out  1  SRAM request / write.
- m_be  out  4; m_addr  out  ADDR_W; m_wdata  out  32  to SRAM.
- m_rdata  in  32; m_gnt, m_rvalid, m_err  in  1  from SRAM.

## Operation
- Frame: 4 address bytes, 4 length bytes (both little-endian), LEN payload bytes, then (with macro) 1 checksum byte.
- States: IDLE → HDR (8 bytes) → DATA ⇄ WRITE → [CKSUM] → DONE → IDLE.
- IDLE: first accepted byte is address byte 0; enter HDR counting 1. ld_err cleared.
- HDR: accept 8 bytes total; after byte 8, LEN==0 → CKSUM (macro) or DONE; else DATA.
- DATA: accept one byte, latch it, → WRITE.
- WRITE: m_req=1, m_we=1, m_addr=cur_addr, m_be=1<<cur_addr[1:0], m_wdata=byte replicated on all 4 lanes. Hold until m_gnt; then cur_addr+=1 (wraps modulo 2^ADDR_W), remaining-=1; remaining 0 → CKSUM/DONE, else DATA.
- DONE: ld_done=1 for one cycle; core_hold←0 unless ld_err; → IDLE.
- ld_ready=1 in IDLE, HDR, DATA, CKSUM; 0 in WRITE, DONE.
- Port ownership: loader owns SRAM port in every state except IDLE. In IDLE, m_* = c_* and c_gnt=m_gnt. Outside IDLE, c_gnt=0 and c_req not forwarded.
- Response routing: 1-bit owner flag captured on each m_req&m_gnt; m_rvalid with owner=core → c_rvalid=1, c_rdata=m_rdata, c_err=m_err; with owner=loader → discarded. A core request granted in the same cycle IDLE is left still receives its response.
- Loader never reads SRAM; m_err on loader writes ignored.

## Timing
- Reset values: ld_ready=1, ld_busy=0, ld_done=0, ld_err=0, core_hold=1, c_gnt=m_gnt passthrough, c_rvalid=0, m_req=0, owner=core.
- With m_gnt tied 1: 2 cycles per payload byte (DATA accept, WRITE); frame of N bytes completes N×2+8(+1) cycles after first byte with back-to-back ld_valid.
- m_* outputs of WRITE are combinational from registered state; stable until m_gnt.
- Reset mid-frame: returns to IDLE, core_hold=1, partial writes remain in SRAM.
- ld_valid ignored while ld_ready=0; no byte lost.

## Configuration
- LOADER_CHECKSUM_EN defined: CKSUM state present; running 8-bit sum of all header and payload bytes; checksum byte must make total sum ≡ 0 mod 256; mismatch sets ld_err, core_hold stays at its prior value, ld_done still pulses.
- Undefined: no CKSUM state, frame ends after last payload write, ld_err tied 0.

## Test plan
- Frame addr=0x00000100, LEN=4, bytes 11 22 33 44, m_gnt=1 → four writes be=1,2,4,8 at 0x100..0x103, ld_done pulse, core_hold falls.
- LEN=0 → no m_req, ld_done after header (and checksum byte), core_hold falls.
- m_gnt held 0 for 5 cycles in WRITE → m_req/m_addr/m_wdata stable, ld_ready=0, write completes on gnt.
- Idle core read at 0x8 with SRAM rvalid next cycle → c_rvalid=1, c_rdata=m_rdata; core request during HDR → c_gnt=0.
- Address 0xFFFFFFFF, LEN=2 → writes at 0xFFFFFFFF then 0x00000000 (be=8 then 1).
- Macro on: bad checksum → ld_err=1, core_hold stays 1; rst_n asserted mid-DATA → all outputs to reset values immediately.
